// File: rtl/neuron_step_sequencer.sv
// Single-neuron step controller: loads parameters into a potential_adder, accumulates
// synaptic weights, applies leak and sequences one adder evaluation per time step.

`ifndef DEFAULT
`define DEFAULT 3'd0
`define A       3'd1
`define B       3'd2
`define C       3'd3
`define D       3'd4
`define VT      3'd5
`define U       3'd6
`endif

`ifndef LIF
`define LIF     2'd0
`define IZHI_AD 2'd1
`define QLIF    2'd2
`endif

module neuron_step_sequencer #(
   parameter int DECAY_SHIFT = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [2:0]  cfg_sel,
   input  logic [31:0] cfg_data,
   input  logic [1:0]  model_in,
   input  logic        w_valid,
   output logic        w_ready,
   input  logic [31:0] w_data,
   input  logic        step_req,
   output logic        step_busy,
   output logic        step_done,
   output logic        spike_out,
   output logic [31:0] potential_out,
   output logic        timeout_err,
   output logic        add_time_step,
   output logic [31:0] add_input_weight,
   output logic [31:0] add_decayed_potential,
   output logic [1:0]  add_model,
   output logic [2:0]  add_init_mode,
   output logic        add_load,
   output logic        add_rst,
   input  logic [31:0] add_final_potential,
   input  logic        add_done,
   input  logic        add_spike
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CFG_SET,
      S_CFG_LOAD,
      S_CFG_HOLD,
      S_ARM0,
      S_ARM1,
      S_WAIT,
      S_WB
   } state_t;

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t           state, state_nxt;
   logic [31:0]      p, acc, wreg, dreg, cfg_data_q;
   logic [2:0]       cfg_sel_q;
   logic [1:0]       model_q;
   logic [CNT_W-1:0] wait_cnt;
   logic             seen_low;

   logic [32:0]      acc_sum;
   logic [31:0]      acc_in, decayed;
   logic             step_go, cfg_fire, cfg_legal, done_ok, timed_out;

   // Saturating weight accumulation; the weight arriving with step_req still counts.
   assign acc_sum   = {1'b0, acc} + {1'b0, w_data};
   assign acc_in    = !w_valid ? acc : (acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0]);
   assign decayed   = p - (p >> DECAY_SHIFT);

   assign step_go   = (state == S_IDLE) && step_req;
   assign cfg_fire  = (state == S_IDLE) && cfg_valid && !step_req;
   assign cfg_legal = cfg_sel inside {`A, `B, `C, `D, `VT, `U};
   // A done left high from the previous step is ignored until a low has been observed.
   assign done_ok   = add_done && seen_low;
   assign timed_out = (state == S_WAIT) && !done_ok && (wait_cnt == CNT_W'(TIMEOUT - 1));

   assign potential_out = p;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every output and next-state value gets a default before the case, so no latch can form.
   always_comb begin
      state_nxt             = state;
      cfg_ready             = 1'b0;
      w_ready               = 1'b0;
      step_busy             = 1'b1;
      step_done             = 1'b0;
      add_time_step         = 1'b0;
      add_input_weight      = 32'd0;
      add_decayed_potential = 32'd0;
      add_model             = `LIF;
      add_init_mode         = `DEFAULT;
      add_load              = 1'b0;
      add_rst               = 1'b0;
      case (state)
         S_IDLE: begin
            step_busy = 1'b0;
            w_ready   = 1'b1;
            cfg_ready = !step_req;
            if (step_req)
               state_nxt = S_ARM0;
            else if (cfg_valid && cfg_legal)
               state_nxt = S_CFG_SET;
         end
         S_CFG_SET, S_CFG_LOAD, S_CFG_HOLD: begin
            add_init_mode    = cfg_sel_q;
            add_input_weight = cfg_data_q;
            add_load         = (state == S_CFG_LOAD);
            state_nxt        = (state == S_CFG_SET)  ? S_CFG_LOAD :
                               (state == S_CFG_LOAD) ? S_CFG_HOLD : S_IDLE;
         end
         S_ARM0, S_ARM1, S_WAIT, S_WB: begin
            add_input_weight      = wreg;
            add_decayed_potential = dreg;
            add_model             = model_q;
            add_time_step         = (state == S_ARM0) || (state == S_ARM1);
            step_done             = (state == S_WB);
            case (state)
               S_ARM0:  state_nxt = S_ARM1;
               S_ARM1:  state_nxt = S_WAIT;
               S_WAIT: begin
                  if (done_ok) begin
                     state_nxt = S_WB;
                  end else if (timed_out) begin
                     add_rst   = 1'b1;
                     state_nxt = S_IDLE;
                  end
               end
               default: state_nxt = S_IDLE;
            endcase
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p           <= 32'd0;
         acc         <= 32'd0;
         wreg        <= 32'd0;
         dreg        <= 32'd0;
         cfg_data_q  <= 32'd0;
         cfg_sel_q   <= `DEFAULT;
         model_q     <= `LIF;
         wait_cnt    <= '0;
         seen_low    <= 1'b0;
         spike_out   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (step_go) begin
            wreg     <= acc_in;
            acc      <= 32'd0;
            dreg     <= (model_in == `IZHI_AD) ? p : decayed;
            model_q  <= model_in;
            seen_low <= 1'b0;
         end else if (state == S_IDLE) begin
            acc <= acc_in;
            if (cfg_fire) begin
               cfg_sel_q  <= cfg_sel;
               cfg_data_q <= cfg_data;
               if (cfg_sel == `DEFAULT) p <= cfg_data;
            end
         end

         if ((state == S_ARM0 || state == S_ARM1 || state == S_WAIT) && !add_done)
            seen_low <= 1'b1;

         if (state == S_ARM1)      wait_cnt <= '0;
         else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;

         if (timed_out) timeout_err <= 1'b1;

         if (state == S_WB) begin
            p         <= add_final_potential;
            spike_out <= add_spike;
         end
      end
   end

endmodule
